// File: rtl/can_pkg.sv
// Shared CAN TX types: frame bundle, sequencer states and field widths.
package can_pkg;

    localparam int CAN_ID_W      = 11;
    localparam int CAN_DLC_W     = 4;
    localparam int CAN_MAX_BYTES = 8;

    typedef struct packed {
        logic [CAN_ID_W-1:0]            id;
        logic [CAN_DLC_W-1:0]           dlc;
        logic [CAN_MAX_BYTES-1:0][7:0]  data;
    } can_frame_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_IDLE,
        S_ACTIVE,
        S_BACKOFF,
        S_RELEASE,
        S_SETTLE
    } tx_seq_state_e;

endpackage

// File: rtl/can_tx_backoff_cnt.sv
// Loadable down-counter timing the post-error back-off window.
module can_tx_backoff_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic         clear,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/can_tx_sequencer.sv
// CAN TX sequencer: arms the bit engine, handles retries, bus-off and abort.
// Optional macro CAN_TX_RETRY_LIMIT_EN aborts after MAX_RETRY error retries.
module can_tx_sequencer
    import can_pkg::*;
#(
    parameter int BACKOFF_CYC = 11,
    parameter int MAX_RETRY   = 16,
    parameter int RETRY_W     = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start_tx,
    input  logic [CAN_ID_W-1:0]        tx_id,
    input  logic [CAN_DLC_W-1:0]       tx_dlc,
    input  logic [CAN_MAX_BYTES*8-1:0] tx_data,
    output logic                       tx_done,
    input  logic                       bus_idle,
    input  logic                       bus_off,
    input  logic                       abort_req,
    output logic                       eng_start,
    output logic [CAN_ID_W-1:0]        eng_id,
    output logic [CAN_DLC_W-1:0]       eng_dlc,
    output logic [CAN_MAX_BYTES*8-1:0] eng_data,
    input  logic                       eng_ok,
    input  logic                       eng_arb_lost,
    input  logic                       eng_err,
    output logic                       tx_ok,
    output logic                       tx_abort,
    output logic [RETRY_W-1:0]         retry_cnt,
    output logic                       busy
);

    localparam int BO_W = (BACKOFF_CYC > 1) ? $clog2(BACKOFF_CYC) : 1;
    localparam logic [BO_W-1:0] BO_LOAD = BO_W'(BACKOFF_CYC - 1);

    if (2 ** RETRY_W <= MAX_RETRY) begin : g_bad_retry_w
        $error("RETRY_W too narrow for MAX_RETRY");
    end

    tx_seq_state_e      state;
    can_frame_t         frame;
    logic               abort_pend;
    logic               abort_any;
    logic               limit_hit;
    logic               bo_load;
    logic               bo_clear;
    logic               bo_zero;
    logic [RETRY_W-1:0] retry_inc;

`ifdef CAN_TX_RETRY_LIMIT_EN
    assign limit_hit = (retry_cnt == RETRY_W'(MAX_RETRY - 1));
`else
    assign limit_hit = 1'b0;
`endif

    // An abort raised in the same cycle as a loss/error counts as pending.
    assign abort_any = abort_pend | abort_req;
    assign retry_inc = (&retry_cnt) ? retry_cnt : retry_cnt + 1'b1;

    assign bo_load  = (state == S_ACTIVE) && !eng_ok && !bus_off &&
                      eng_err && !abort_any && !limit_hit;
    assign bo_clear = (state == S_BACKOFF) && (abort_req || bus_off);

    can_tx_backoff_cnt #(
        .W(BO_W)
    ) u_backoff (
        .clk      (clk),
        .rst      (rst),
        .load     (bo_load),
        .clear    (bo_clear),
        .en       (state == S_BACKOFF),
        .load_val (BO_LOAD),
        .zero     (bo_zero)
    );

    assign eng_id   = frame.id;
    assign eng_dlc  = frame.dlc;
    assign eng_data = frame.data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= S_IDLE;
            frame      <= '0;
            abort_pend <= 1'b0;
            retry_cnt  <= '0;
            eng_start  <= 1'b0;
            tx_done    <= 1'b0;
            tx_ok      <= 1'b0;
            tx_abort   <= 1'b0;
            busy       <= 1'b0;
        end else begin
            eng_start <= 1'b0;
            tx_done   <= 1'b0;
            tx_ok     <= 1'b0;
            tx_abort  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (start_tx && !bus_off) begin
                        frame <= {tx_id, tx_dlc, tx_data};
                        busy  <= 1'b1;
                        state <= S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    if (abort_req) begin
                        tx_done  <= 1'b1;
                        tx_abort <= 1'b1;
                        state    <= S_RELEASE;
                    end else if (bus_idle && !bus_off) begin
                        eng_start <= 1'b1;
                        state     <= S_ACTIVE;
                    end
                end
                S_ACTIVE: begin
                    if (abort_req) begin
                        abort_pend <= 1'b1;
                    end
                    if (eng_ok) begin
                        abort_pend <= 1'b0;
                        tx_done    <= 1'b1;
                        tx_ok      <= 1'b1;
                        state      <= S_RELEASE;
                    end else if (bus_off) begin
                        state <= S_WAIT_IDLE;
                    end else if (eng_err) begin
                        retry_cnt <= retry_inc;
                        if (abort_any || limit_hit) begin
                            tx_done  <= 1'b1;
                            tx_abort <= 1'b1;
                            state    <= S_RELEASE;
                        end else begin
                            state <= S_BACKOFF;
                        end
                    end else if (eng_arb_lost) begin
                        if (abort_any) begin
                            tx_done  <= 1'b1;
                            tx_abort <= 1'b1;
                            state    <= S_RELEASE;
                        end else begin
                            state <= S_WAIT_IDLE;
                        end
                    end
                end
                S_BACKOFF: begin
                    if (abort_req) begin
                        tx_done  <= 1'b1;
                        tx_abort <= 1'b1;
                        state    <= S_RELEASE;
                    end else if (bus_off || bo_zero) begin
                        state <= S_WAIT_IDLE;
                    end
                end
                S_RELEASE: begin
                    retry_cnt  <= '0;
                    abort_pend <= 1'b0;
                    state      <= S_SETTLE;
                end
                S_SETTLE: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_can_tx_sequencer.sv
// Bench for can_tx_sequencer: vector table, corner sequences, random vs model.
module tb_can_tx_sequencer;
    import can_pkg::*;

    localparam int BO = 11;
    localparam int MR = 2;
    localparam int RW = 5;
`ifdef CAN_TX_RETRY_LIMIT_EN
    localparam bit LIMIT = 1'b1;
`else
    localparam bit LIMIT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_tx = 0, bus_idle = 0, bus_off = 0, abort_req = 0;
    logic eng_ok = 0, eng_arb_lost = 0, eng_err = 0;
    logic [10:0] tx_id = '0;
    logic [3:0]  tx_dlc = '0;
    logic [63:0] tx_data = '0;
    logic tx_done, eng_start, tx_ok, tx_abort, busy;
    logic [10:0] eng_id;
    logic [3:0]  eng_dlc;
    logic [63:0] eng_data;
    logic [RW-1:0] retry_cnt;

    int checks = 0;
    int passed = 0;

    can_tx_sequencer #(
        .BACKOFF_CYC(BO), .MAX_RETRY(MR), .RETRY_W(RW)
    ) dut (
        .clk(clk), .rst(rst), .start_tx(start_tx), .tx_id(tx_id),
        .tx_dlc(tx_dlc), .tx_data(tx_data), .tx_done(tx_done),
        .bus_idle(bus_idle), .bus_off(bus_off), .abort_req(abort_req),
        .eng_start(eng_start), .eng_id(eng_id), .eng_dlc(eng_dlc),
        .eng_data(eng_data), .eng_ok(eng_ok), .eng_arb_lost(eng_arb_lost),
        .eng_err(eng_err), .tx_ok(tx_ok), .tx_abort(tx_abort),
        .retry_cnt(retry_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h want %0h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic quiet();
        {start_tx, bus_idle, eng_ok, eng_err, eng_arb_lost, abort_req, bus_off} = '0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic wait_start(input int lim, output int n);
        n = 0;
        while (n < lim && !eng_start) begin
            step();
            n++;
        end
    endtask

    task automatic start_frame();
        int n;
        start_tx = 1'b1;
        bus_idle = 1'b1;
        step();
        start_tx = 1'b0;
        wait_start(5, n);
        chk("frame start", eng_start, 1'b1);
    endtask

    function automatic logic [88:0] all_outs();
        return {eng_start, tx_done, tx_ok, tx_abort, busy, retry_cnt,
                eng_id, eng_dlc, eng_data};
    endfunction

    typedef struct {
        logic [6:0] stim;
        logic [4:0] exp;
        int         retry;
    } vec_t;
    vec_t tbl[$];

    function automatic void add(logic [6:0] s, logic [4:0] e, int r);
        tbl.push_back('{stim: s, exp: e, retry: r});
    endfunction

    // Reference model state, in terms of frame lifetime rather than states.
    bit m_held, m_bus, m_pend;
    int m_cool, m_fin, m_retry;
    logic [10:0] m_id;
    logic [3:0]  m_dlc;
    logic [63:0] m_data;
    bit e_start, e_done, e_ok, e_abort, e_busy;

    task automatic m_reset();
        m_held = 0; m_bus = 0; m_pend = 0;
        m_cool = 0; m_fin = 0; m_retry = 0;
        m_id = '0; m_dlc = '0; m_data = '0;
        e_start = 0; e_done = 0; e_ok = 0; e_abort = 0; e_busy = 0;
    endtask

    task automatic m_rel(input bit ok);
        m_fin = 2; m_bus = 0; m_cool = 0;
        e_done = 1; e_ok = ok; e_abort = !ok;
    endtask

    task automatic m_step();
        bit pend_now, lim;
        e_start = 0; e_done = 0; e_ok = 0; e_abort = 0;
        if (m_fin == 2) begin
            m_retry = 0; m_pend = 0; m_fin = 1;
        end else if (m_fin == 1) begin
            m_fin = 0; m_held = 0; e_busy = 0;
        end else if (!m_held) begin
            if (start_tx && !bus_off) begin
                m_held = 1; e_busy = 1;
                m_id = tx_id; m_dlc = tx_dlc; m_data = tx_data;
            end
        end else if (m_bus) begin
            pend_now = m_pend || abort_req;
            if (abort_req) m_pend = 1;
            if (eng_ok) begin
                m_pend = 0;
                m_rel(1);
            end else if (bus_off) begin
                m_bus = 0;
            end else if (eng_err) begin
                m_bus = 0;
                lim = LIMIT && (m_retry == MR - 1);
                if (m_retry < (1 << RW) - 1) m_retry++;
                if (pend_now || lim) m_rel(0);
                else m_cool = BO;
            end else if (eng_arb_lost) begin
                m_bus = 0;
                if (pend_now) m_rel(0);
            end
        end else if (m_cool > 0) begin
            if (abort_req) m_rel(0);
            else if (bus_off) m_cool = 0;
            else m_cool--;
        end else begin
            if (abort_req) m_rel(0);
            else if (bus_idle && !bus_off) begin
                m_bus = 1; e_start = 1;
            end
        end
    endtask

    initial begin
        int n;
        bit seen;
        do_reset();
        @(negedge clk);
        chk("reset outputs", all_outs(), '0);

        // stim = {start,idle,ok,err,arb,abort,bus_off}
        // exp  = {eng_start,tx_done,tx_ok,tx_abort,busy}
        add(7'b1100000, 5'b00001, 0);
        add(7'b0100000, 5'b10001, 0);
        repeat (5) add(7'b0000000, 5'b00001, 0);
        add(7'b0010000, 5'b01101, 0);
        add(7'b0000000, 5'b00001, 0);
        add(7'b1000000, 5'b00000, 0);
        add(7'b1000000, 5'b00001, 0);
        add(7'b0100000, 5'b10001, 0);
        add(7'b0000100, 5'b00001, 0);
        add(7'b0000000, 5'b00001, 0);
        add(7'b0100000, 5'b10001, 0);
        add(7'b0000010, 5'b00001, 0);
        add(7'b0010000, 5'b01101, 0);
        add(7'b0000000, 5'b00001, 0);
        add(7'b0000000, 5'b00000, 0);
        add(7'b1000000, 5'b00001, 0);
        add(7'b0100000, 5'b10001, 0);
        add(7'b0000010, 5'b00001, 0);
        add(7'b0001000, 5'b01011, 1);
        add(7'b0000000, 5'b00001, 0);
        add(7'b0000000, 5'b00000, 0);
        add(7'b1000000, 5'b00001, 0);
        add(7'b0000010, 5'b01011, 0);
        add(7'b0000000, 5'b00001, 0);
        add(7'b0000000, 5'b00000, 0);
        add(7'b1000001, 5'b00000, 0);
        add(7'b1000000, 5'b00001, 0);

        tx_id = 11'd100;
        tx_dlc = 4'd8;
        tx_data = 64'h0123_4567_89ab_cdef;
        foreach (tbl[k]) begin
            {start_tx, bus_idle, eng_ok, eng_err, eng_arb_lost,
             abort_req, bus_off} = tbl[k].stim;
            step();
            chk($sformatf("vec%0d flags", k),
                {eng_start, tx_done, tx_ok, tx_abort, busy}, tbl[k].exp);
            chk($sformatf("vec%0d retry", k), retry_cnt, RW'(tbl[k].retry));
            if (k == 0) chk("latched id", eng_id, 11'd100);
        end

        // Error back-off, and the retry limit when enabled.
        do_reset();
        tx_id = 11'h2a5;
        start_frame();
        for (int e = 1; e <= 3; e++) begin
            eng_err = 1'b1;
            step();
            eng_err = 1'b0;
            if (LIMIT && e == MR) begin
                chk("limit abort", {tx_done, tx_ok, tx_abort}, 3'b101);
                seen = 0;
                repeat (30) begin
                    step();
                    seen |= eng_start;
                end
                chk("no restart after limit", seen, 1'b0);
                break;
            end
            wait_start(40, n);
            chk($sformatf("restart %0d", e), eng_start, 1'b1);
            chk($sformatf("gap %0d", e), (n + 1 >= BO + 2), 1'b1);
            chk($sformatf("retry %0d", e), retry_cnt, RW'(e));
        end
        if (!LIMIT) begin
            eng_ok = 1'b1;
            step();
            eng_ok = 1'b0;
            chk("ok after retries", {tx_done, tx_ok, tx_abort}, 3'b110);
            step();
            chk("retry cleared", retry_cnt, '0);
        end

        // Bus-off during back-off holds the frame until bus-off clears.
        do_reset();
        start_frame();
        eng_err = 1'b1;
        step();
        eng_err = 1'b0;
        repeat (3) step();
        bus_off = 1'b1;
        seen = 0;
        repeat (20) begin
            step();
            seen |= eng_start;
        end
        chk("no start while bus_off", seen, 1'b0);
        chk("busy while bus_off", busy, 1'b1);
        chk("retry kept in bus_off", retry_cnt, RW'(1));
        bus_off = 1'b0;
        wait_start(3, n);
        chk("start after bus_off", eng_start, 1'b1);
        eng_ok = 1'b1;
        step();
        eng_ok = 1'b0;
        chk("ok after bus_off", tx_ok, 1'b1);

        // Reset mid-frame clears everything at once and frees nothing.
        do_reset();
        tx_id = 11'h7ff;
        start_frame();
        step();
        rst = 1'b1;
        eng_ok = 1'b1;
        #1;
        chk("async reset outputs", all_outs(), '0);
        @(negedge clk);
        rst = 1'b0;
        eng_ok = 1'b0;
        seen = 0;
        repeat (6) begin
            step();
            seen |= tx_done;
        end
        chk("no done after reset", seen, 1'b0);
        chk("idle after reset", all_outs(), '0);

        // Random traffic against the reference model.
        do_reset();
        m_reset();
        repeat (3000) begin
            start_tx     = ($urandom_range(0, 1) == 0);
            bus_idle     = ($urandom_range(0, 9) < 7);
            bus_off      = ($urandom_range(0, 19) == 0);
            abort_req    = ($urandom_range(0, 39) == 0);
            eng_ok       = ($urandom_range(0, 11) == 0);
            eng_err      = ($urandom_range(0, 11) == 0);
            eng_arb_lost = ($urandom_range(0, 11) == 0);
            tx_id        = 11'($urandom);
            tx_dlc       = 4'($urandom);
            tx_data      = {$urandom, $urandom};
            @(posedge clk);
            m_step();
            @(negedge clk);
            chk("random", all_outs(),
                {e_start, e_done, e_ok, e_abort, e_busy, RW'(m_retry),
                 m_id, m_dlc, m_data});
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/can_tx_sequencer.md
# can_tx_sequencer

Controller that sequences the CAN transmit path. It takes the frame currently selected by `can_tx_priority` (the lowest pending ID), holds it stable, and starts the bit-level TX engine only when the bus is idle. It handles arbitration loss, error retransmission with back-off, bus-off and host abort. It returns `tx_done` to the priority queue so the entry is freed only after success or abort.

## Interface
Parameters:
- `BACKOFF_CYC`, 11: clock cycles waited after an error frame before re-arming.
- `MAX_RETRY`, 16: error retransmissions allowed before abort (used only with the macro in Configuration).
- `RETRY_W`, 5: width of the retry counter; must satisfy 2^RETRY_W > MAX_RETRY.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: reset, asynchronous and active-high.
- `start_tx` in 1: the priority queue has a selected frame.
- `tx_id` in 11, `tx_dlc` in 4, `tx_data` in 8x8: the selected frame from the queue.
- `tx_done` out 1: one-cycle pulse that frees the queue entry.
- `bus_idle` in 1: the bus has been recessive for the intermission period.
- `bus_off` in 1: error-confinement state is bus-off.
- `abort_req` in 1: host level request to abandon the current frame.
- `eng_start` out 1: one-cycle pulse to the TX engine.
- `eng_id` out 11, `eng_dlc` out 4, `eng_data` out 8x8: latched frame driven to the engine.
- `eng_ok` in 1: pulse, frame transmitted and acknowledged.
- `eng_arb_lost` in 1: pulse, arbitration lost.
- `eng_err` in 1: pulse, error frame occurred.
- `tx_ok` out 1: pulse, frame completed successfully.
- `tx_abort` out 1: pulse, frame abandoned.
- `retry_cnt` out RETRY_W: error retransmissions for the current frame.
- `busy` out 1: high in every state except IDLE.

## Operation
States: IDLE, WAIT_IDLE, ACTIVE, BACKOFF, RELEASE, SETTLE.

- **IDLE**
  - `start_tx`=1 and `bus_off`=0: latch `tx_id`/`tx_dlc`/`tx_data` into the `eng_*` registers and go to WAIT_IDLE.
  - `eng_*` outputs hold their value outside this latch.
- **WAIT_IDLE**
  - `abort_req` goes to RELEASE (aborted).
  - Otherwise `bus_idle`=1 and `bus_off`=0 goes to ACTIVE.
  - `abort_req` has priority over `bus_idle`.
- **ACTIVE**
  - First cycle: `eng_start`=1.
  - `eng_ok` goes to RELEASE (success).
  - `eng_arb_lost` goes to WAIT_IDLE; `retry_cnt` is unchanged.
  - `eng_err` increments `retry_cnt` and goes to BACKOFF.
  - Simultaneous events resolve in the order `eng_ok` > `eng_err` > `eng_arb_lost`.
  - `abort_req` seen in ACTIVE sets a sticky `abort_pend` and does not stop the frame on the bus.
  - After arbitration loss or error with `abort_pend` set, go to RELEASE (aborted).
  - After `eng_ok`, the frame completes as success and `abort_pend` clears.
- **BACKOFF**
  - Load `BACKOFF_CYC`-1 on entry and count down to 0, then go to WAIT_IDLE.
  - `abort_req` goes to RELEASE (aborted) immediately.
- **bus_off**
  - `bus_off`=1 in ACTIVE or BACKOFF forces WAIT_IDLE.
  - The frame stays latched and `retry_cnt` is unchanged.
  - WAIT_IDLE holds while `bus_off`=1.
- **RELEASE**
  - One cycle with `tx_done`=1, plus exactly one of `tx_ok`/`tx_abort`=1.
  - Clear `retry_cnt` and `abort_pend`, then go to SETTLE.
- **SETTLE**
  - One cycle; `start_tx` is ignored so the queue can re-select.
  - Then go to IDLE.

## Timing
- Reset values:
  - state IDLE.
  - `tx_done`, `eng_start`, `tx_ok`, `tx_abort`, `busy` are 0.
  - `retry_cnt` 0; `eng_id`/`eng_dlc`/`eng_data` all 0.
  - `abort_pend` 0; back-off counter 0.
- Reset asserted mid-frame returns everything to reset values immediately. No `tx_done` is issued.
- All outputs are registered.
- `start_tx` sampled at edge 0 with `bus_idle`=1 at edge 1 gives `eng_start` during cycle 2. This is the minimum latency of 2.
- `eng_ok` sampled at edge n gives `tx_done`/`tx_ok` during cycle n+1, SETTLE at n+2 and IDLE at n+3.
- The earliest next `start_tx` sample is at the end of cycle n+3.
- `eng_err` to the next `eng_start` takes at least `BACKOFF_CYC`+2 cycles.
- `retry_cnt` saturates at 2^RETRY_W-1.

## Configuration
- `CAN_TX_RETRY_LIMIT_EN` defined:
  - On `eng_err` with `retry_cnt`==MAX_RETRY-1, increment and go directly to RELEASE (aborted) instead of BACKOFF.
- Not defined:
  - Retransmission is unlimited per ISO 11898 and `MAX_RETRY` is unused.

## Structure
- Package `can_pkg` holds:
  - `can_frame_t` (id 11, dlc 4, data 8x8).
  - `tx_seq_state_e` enum.
  - `CAN_ID_W`=11, `CAN_DLC_W`=4, `CAN_MAX_BYTES`=8.
- Sub-module `can_tx_backoff_cnt`: loadable down-counter with `load`, `clear` and `zero` outputs, used for BACKOFF.

## Test plan
- **Success:** after reset, `start_tx`=1, `tx_id`=100, `bus_idle`=1, then `eng_ok` 5 cycles after `eng_start` -> `eng_start` in cycle 2, `eng_id`=100, one `tx_done`+`tx_ok` pulse, `retry_cnt`=0.
- **Arbitration loss:** `eng_arb_lost` in ACTIVE -> back to WAIT_IDLE, second `eng_start` when `bus_idle` returns, `retry_cnt`=0, no `tx_done`.
- **Back-off:** 3 consecutive `eng_err` with `BACKOFF_CYC`=11 -> `retry_cnt`=3, each re-start ≥13 cycles after its error, then `eng_ok` -> `tx_ok`, `retry_cnt` cleared.
- **Retry limit:** with `CAN_TX_RETRY_LIMIT_EN` and `MAX_RETRY`=2, two `eng_err` -> `tx_abort`+`tx_done` and no third `eng_start`; without the macro, a third `eng_start` occurs.
- **Abort:** `abort_req` in ACTIVE, then `eng_ok` -> `tx_ok` and not `tx_abort`. `abort_req` in ACTIVE, then `eng_err` -> `tx_abort`.
- **Bus-off and reset:** `bus_off`=1 during BACKOFF -> WAIT_IDLE holds with no `eng_start` until `bus_off`=0. `rst` pulse mid-ACTIVE -> all outputs 0 and no `tx_done`.
